// File: rtl/datapath.sv
// Datapath: 16x16 register file, 8-op ALU with registered Z/N/C flags, 256x16 read-first data memory.
// Optional macro DP_BYPASS_EN adds same-cycle write-through on both register-file read ports.
module datapath (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  D_Addr,
  input  logic        D_wr,
  input  logic        RF_s,
  input  logic [3:0]  RF_W_Addr,
  input  logic        RF_W_en,
  input  logic [3:0]  RF_Ra_Addr,
  input  logic [3:0]  RF_Rb_Addr,
  input  logic [2:0]  ALU_s0,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [15:0] ALU_Out,
  output logic [15:0] R_data,
  output logic        Flag_Z,
  output logic        Flag_N,
  output logic        Flag_C
);

  localparam int unsigned DW        = 16;
  localparam int unsigned RF_DEPTH  = 16;
  localparam int unsigned MEM_DEPTH = 256;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_PSA = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_INC = 3'd7;

  logic [DW-1:0] r_rf  [RF_DEPTH];
  logic [DW-1:0] r_mem [MEM_DEPTH];
  logic [DW-1:0] r_rdata;
  logic          r_z;
  logic          r_n;
  logic          r_c;

  logic [DW-1:0] w_rf_a;
  logic [DW-1:0] w_rf_b;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_inc;
  logic [DW-1:0] w_alu_out;
  logic          w_alu_c;
  logic [DW-1:0] w_wdata;

  assign w_rf_a = r_rf[RF_Ra_Addr];
  assign w_rf_b = r_rf[RF_Rb_Addr];

  assign w_sum = {1'b0, w_rf_a} + {1'b0, w_rf_b};
  assign w_inc = {1'b0, w_rf_a} + (DW+1)'(1);

  // ALU works on the raw array reads so that write-through cannot form a loop.
  always_comb begin
    w_alu_out = '0;
    w_alu_c   = 1'b0;
    case (ALU_s0)
      OP_ADD: begin
        w_alu_out = w_sum[DW-1:0];
        w_alu_c   = w_sum[DW];
      end
      OP_SUB: begin
        w_alu_out = w_rf_a - w_rf_b;
        w_alu_c   = (w_rf_a < w_rf_b);
      end
      OP_PSA: w_alu_out = w_rf_a;
      OP_XOR: w_alu_out = w_rf_a ^ w_rf_b;
      OP_OR:  w_alu_out = w_rf_a | w_rf_b;
      OP_AND: w_alu_out = w_rf_a & w_rf_b;
      OP_INC: begin
        w_alu_out = w_inc[DW-1:0];
        w_alu_c   = w_inc[DW];
      end
      default: w_alu_out = '0;
    endcase
  end

  assign w_wdata = RF_s ? r_rdata : w_alu_out;

`ifdef DP_BYPASS_EN
  assign ALU_A = (RF_W_en && !Reset && (RF_Ra_Addr == RF_W_Addr)) ? w_wdata : w_rf_a;
  assign ALU_B = (RF_W_en && !Reset && (RF_Rb_Addr == RF_W_Addr)) ? w_wdata : w_rf_b;
`else
  assign ALU_A = w_rf_a;
  assign ALU_B = w_rf_b;
`endif

  assign ALU_Out = w_alu_out;
  assign R_data  = r_rdata;
  assign Flag_Z  = r_z;
  assign Flag_N  = r_n;
  assign Flag_C  = r_c;

  // Register file: reset clears every entry and blocks the write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (RF_W_en) begin
      r_rf[RF_W_Addr] <= w_wdata;
    end
  end

  // Data memory array: contents survive reset.
  always_ff @(posedge Clk) begin
    if (D_wr && !Reset) begin
      r_mem[D_Addr] <= ALU_A;
    end
  end

  // Read-first registered read port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[D_Addr];
    end
  end

  // Flags track only ALU results that are written back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
    end else if (RF_W_en && !RF_s) begin
      r_z <= (w_alu_out == '0);
      r_n <= w_alu_out[DW-1];
      r_c <= w_alu_c;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed vector table, hand sequences and random stimulus vs a reference model.
module tb_datapath;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [15:0] ALU_A;
  logic [15:0] ALU_B;
  logic [15:0] ALU_Out;
  logic [15:0] R_data;
  logic        Flag_Z;
  logic        Flag_N;
  logic        Flag_C;

  datapath dut (
    .Clk(Clk), .Reset(Reset), .D_Addr(D_Addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_Out(ALU_Out), .R_data(R_data), .Flag_Z(Flag_Z), .Flag_N(Flag_N),
    .Flag_C(Flag_C)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_rf  [16];
  logic [15:0] m_mem [256];
  logic [15:0] m_rdata;
  logic        m_z, m_n, m_c;
  bit          g_chk;
  bit          g_rd_ok;
  logic [15:0] s_a, s_b, s_out, s_rd;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        z;
    logic        n;
    logic        c;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic: {carry, result}.
  function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    int unsigned r  = 0;
    logic        c  = 1'b0;
    case (op)
      3'd1: begin r = ia + ib; c = (r >= 65536); end
      3'd2: begin r = ia + 65536 - ib; c = (ia < ib); end
      3'd3: r = ia;
      3'd4: r = ia ^ ib;
      3'd5: r = ia | ib;
      3'd6: r = ia & ib;
      3'd7: begin r = ia + 1; c = (r >= 65536); end
      default: r = 0;
    endcase
    return {c, 16'(r % 65536)};
  endfunction

  // One clock: drive, sample and compare before the edge, then advance the model.
  task automatic step(input bit rst, input logic [7:0] da, input bit dw, input bit rs,
                      input logic [3:0] wa, input bit we, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [2:0] op);
    logic [16:0] alu;
    logic [15:0] wd, ea, eb;
    Reset = rst; D_Addr = da; D_wr = dw; RF_s = rs; RF_W_Addr = wa;
    RF_W_en = we; RF_Ra_Addr = ra; RF_Rb_Addr = rb; ALU_s0 = op;
    #1;
    alu = ref_alu(op, m_rf[ra], m_rf[rb]);
    wd  = rs ? m_rdata : alu[15:0];
    ea  = m_rf[ra];
    eb  = m_rf[rb];
`ifdef DP_BYPASS_EN
    if (we && !rst && ra == wa) ea = wd;
    if (we && !rst && rb == wa) eb = wd;
`endif
    s_a = ALU_A; s_b = ALU_B; s_out = ALU_Out; s_rd = R_data;
    if (g_chk) begin
      check("model_alu_a", ALU_A, ea);
      check("model_alu_b", ALU_B, eb);
      check("model_alu_out", ALU_Out, alu[15:0]);
      if (g_rd_ok) check("model_r_data", R_data, m_rdata);
      check("model_flag_z", Flag_Z, m_z);
      check("model_flag_n", Flag_N, m_n);
      check("model_flag_c", Flag_C, m_c);
    end
    @(posedge Clk);
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_rdata = '0;
      m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    end else begin
      m_rdata = m_mem[da];
      if (dw) m_mem[da] = ea;
      if (we) m_rf[wa] = wd;
      if (we && !rs) begin
        m_z = (alu[15:0] == 16'h0000);
        m_n = alu[15];
        m_c = alu[16];
      end
    end
    @(negedge Clk);
  endtask

  // Build a constant in a register by shift-and-increment through the ALU.
  task automatic load_const(input logic [3:0] idx, input logic [15:0] v);
    step(0, 8'h00, 0, 0, idx, 1, idx, idx, 3'd0);
    for (int i = 15; i >= 0; i--) begin
      step(0, 8'h00, 0, 0, idx, 1, idx, idx, 3'd1);
      if (v[i]) step(0, 8'h00, 0, 0, idx, 1, idx, idx, 3'd7);
    end
  endtask

  initial begin
    logic [15:0] exp_byp;
    vecs[0]  = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{3'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{3'd0, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd5, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd7, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{3'd7, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1};

    g_chk = 1'b0;
    g_rd_ok = 1'b0;
    step(1, 8'h00, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    g_chk = 1'b1;

    // Zero the whole memory from R0 so every later read is predictable.
    for (int a = 0; a < 256; a++) step(0, 8'(a), 1, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    step(0, 8'h00, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    g_rd_ok = 1'b1;

    // Reset then sweep port A.
    load_const(4'd9, 16'hBEEF);
    step(1, 8'h00, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    for (int r = 0; r < 16; r++) begin
      step(0, 8'h00, 0, 0, 4'd0, 0, 4'(r), 4'(r), 3'd0);
      check($sformatf("reset_sweep_a%0d", r), s_a, 16'h0000);
      if (r == 0) check("reset_r_data", s_rd, 16'h0000);
    end
    check("reset_flag_z", Flag_Z, 1'b0);
    check("reset_flag_n", Flag_N, 1'b0);
    check("reset_flag_c", Flag_C, 1'b0);

    // Memory load path.
    load_const(4'd7, 16'h00A5);
    step(0, 8'h1B, 1, 0, 4'd0, 0, 4'd7, 4'd0, 3'd0);
    step(0, 8'h1B, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    step(0, 8'h1B, 0, 1, 4'd3, 1, 4'd0, 4'd0, 3'd0);
    step(0, 8'h00, 0, 0, 4'd0, 0, 4'd3, 4'd0, 3'd0);
    check("mem_load_rf3", s_a, 16'h00A5);

    // Store then load.
    load_const(4'd5, 16'h1234);
    step(0, 8'h40, 1, 0, 4'd0, 0, 4'd5, 4'd0, 3'd0);
    step(0, 8'h40, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    check("store_load_r_data", R_data, 16'h1234);

    // ALU vector table.
    for (int k = 0; k < 11; k++) begin
      load_const(4'd1, vecs[k].a);
      load_const(4'd2, vecs[k].b);
      step(0, 8'h00, 0, 0, 4'd4, 1, 4'd1, 4'd2, vecs[k].op);
      check($sformatf("vec%0d_alu_out", k), s_out, vecs[k].out);
      check($sformatf("vec%0d_flag_z", k), Flag_Z, vecs[k].z);
      check($sformatf("vec%0d_flag_n", k), Flag_N, vecs[k].n);
      check($sformatf("vec%0d_flag_c", k), Flag_C, vecs[k].c);
      step(0, 8'h00, 0, 0, 4'd0, 0, 4'd4, 4'd0, 3'd0);
      check($sformatf("vec%0d_rf4", k), s_a, vecs[k].out);
    end

    // Same-cycle read/write of R6 (old 7, new 9 via memory).
    load_const(4'd6, 16'h0007);
    load_const(4'd8, 16'h0009);
    step(0, 8'h50, 1, 0, 4'd0, 0, 4'd8, 4'd0, 3'd0);
    step(0, 8'h50, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    step(0, 8'h50, 0, 1, 4'd6, 1, 4'd6, 4'd6, 3'd0);
`ifdef DP_BYPASS_EN
    exp_byp = 16'h0009;
`else
    exp_byp = 16'h0007;
`endif
    check("rw_same_cycle_a", s_a, exp_byp);
    check("rw_same_cycle_rdata", s_rd, 16'h0009);
    step(0, 8'h00, 0, 0, 4'd0, 0, 4'd6, 4'd6, 3'd0);
    check("rw_next_cycle_a", s_a, 16'h0009);

    // Same write with reset asserted: no forwarding, write dropped.
    load_const(4'd6, 16'h0007);
    step(0, 8'h50, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0);
    step(1, 8'h50, 1, 1, 4'd6, 1, 4'd6, 4'd6, 3'd0);
    check("rw_reset_a", s_a, 16'h0007);
    step(0, 8'h50, 0, 0, 4'd0, 0, 4'd6, 4'd6, 3'd0);
    check("rw_reset_dropped", s_a, 16'h0000);
    check("rw_reset_rdata", s_rd, 16'h0000);
    step(0, 8'h00, 0, 0, 4'd0, 0, 4'd6, 4'd6, 3'd0);
    check("reset_keeps_mem", s_rd, 16'h0009);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clk  input  1  system clock; all state updates on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-003 D_Addr  input  8  data memory address.
REQ-004 D_wr  input  1  data memory write enable.
REQ-005 RF_s  input  1  register file write-data select: 1 = data memory read data, 0 = ALU result.
REQ-006 RF_W_Addr  input  4  register file write address.
REQ-007 RF_W_en  input  1  register file write enable.
REQ-008 RF_Ra_Addr  input  4  register file read port A address.
REQ-009 RF_Rb_Addr  input  4  register file read port B address.
REQ-010 ALU_s0  input  3  ALU function select.
REQ-011 ALU_A  output  16  register file port A read data.
REQ-012 ALU_B  output  16  register file port B read data.
REQ-013 ALU_Out  output  16  ALU result.
REQ-014 R_data  output  16  registered data memory read data.
REQ-015 Flag_Z, Flag_N, Flag_C  output  1 each  registered status flags: zero, negative, carry/borrow.

Function
REQ-016 The register file SHALL hold 16 x 16-bit registers with two combinational read ports (A, B) and one write port.
REQ-017 Write port SHALL store W_data = (RF_s ? R_data : ALU_Out) into RF[RF_W_Addr] at the clock edge when RF_W_en=1 and Reset=0.
REQ-018 Without the bypass path, a read of RF_W_Addr in the same cycle as its write SHALL return the old value; the new value SHALL be visible the following cycle.
REQ-019 Data memory SHALL be 256 x 16-bit, inferred internally, with no IP instance.
REQ-020 Memory write: when D_wr=1 and Reset=0, mem[D_Addr] SHALL be loaded with ALU_A at the clock edge.
REQ-021 Memory read: R_data SHALL be updated every edge with mem[D_Addr], giving one-cycle latency.
REQ-022 On a same-address read and write in one cycle, the memory SHALL be read-first: R_data gets the old contents.
REQ-023 ALU_Out SHALL be combinational, with all arithmetic modulo 2^16, per ALU_s0:
  - 0 = 16'h0000
  - 1 = A+B
  - 2 = A-B
  - 3 = A
  - 4 = A^B
  - 5 = A|B
  - 6 = A&B
  - 7 = A+1
REQ-024 Carry-out (ops 1 and 7) SHALL be bit 16 of the 17-bit sum; borrow (op 2) SHALL be 1 when A < B unsigned; other ops SHALL produce 0.
REQ-025 ALU_Out SHALL not depend on memory or on RF_s.

Reset
REQ-026 When Reset=1 at an edge, all 16 registers SHALL clear to 0, R_data SHALL clear to 0, and all flags SHALL clear to 0.
REQ-027 Register and memory writes requested in a reset cycle SHALL be suppressed.
REQ-028 Memory contents SHALL be unaffected by reset.
REQ-029 After reset releases, ALU_A, ALU_B and ALU_Out SHALL reflect the cleared registers combinationally.

Configuration
REQ-030 Macro DP_BYPASS_EN defined: when RF_W_en=1 and a read address equals RF_W_Addr, that read port SHALL return W_data in the same cycle (write-through).
REQ-031 Macro DP_BYPASS_EN defined: the write-through SHALL be suppressed while Reset=1.
REQ-032 Macro DP_BYPASS_EN undefined: REQ-018 behaviour applies.
REQ-033 Flags SHALL update at the edge only when RF_W_en=1 and RF_s=0:
  - Z = (ALU_Out==0)
  - N = ALU_Out[15]
  - C per REQ-024
  Otherwise the flags SHALL hold.

Verification
REQ-034 Reset asserted 1 cycle, then RF_Ra_Addr=0..15 swept -> ALU_A=0 for every address; R_data=0; all flags=0.
REQ-035 Memory load path: preload mem[8'h1B]=16'h00A5; D_Addr=8'h1B, RF_s=1, RF_W_en=1, RF_W_Addr=3 asserted one cycle after the address -> RF[3]=16'h00A5; ALU_A=16'h00A5 when RF_Ra_Addr=3.
REQ-036 ALU path: RF[1]=16'hFFFF, RF[2]=16'h0001, ALU_s0=1, RF_s=0, write RF[4] -> ALU_Out=0; RF[4]=0; Z=1, C=1, N=0.
REQ-037 ALU subtract: ALU_s0=2 with A=16'h0003, B=16'h0005 -> ALU_Out=16'hFFFE; N=1, C=1.
REQ-038 Store then load: RF[5]=16'h1234 stored with D_wr=1 to D_Addr=8'h40 -> next read of 8'h40 gives R_data=16'h1234.
REQ-039 Simultaneous read and write of RF[6] (old 16'h0007, new 16'h0009):
  - DP_BYPASS_EN undefined -> ALU_A=16'h0007 that cycle.
  - DP_BYPASS_EN defined -> ALU_A=16'h0009.
  - Reset asserted in that cycle -> RF[6]=0 and the write is dropped.
